// File: rtl/mod_exp_unit.sv
// mod_exp_unit: base^exponent mod modulus by right-to-left square-and-multiply over a shift-add modular multiplier.
// Optional MODEXP_EARLY_EXIT_EN: stop once no set exponent bits remain (data-dependent latency, same results).
module mod_exp_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, REDUCE, MUL, SQR, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d, e_q, e_d, x_q, x_d, p_q, p_d;
    logic [WIDTH-1:0] acc_q, acc_d, b_q, b_d, res_q, res_d, fin_val;
    logic [CW-1:0]    cnt_q, cnt_d, k_q, k_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d, fin;
    logic [WIDTH-1:0] y, pn;
    logic [WIDTH+1:0] mm, sum, sub;
    logic             last;

    // One interleaved modmul step: P = 2P + (x_msb ? Y : 0), then two conditional subtractions keep P < m.
    assign y    = (state_q == REDUCE) ? WIDTH'(1) : b_q;
    assign mm   = {2'b00, m_q};
    assign sum  = {1'b0, p_q, 1'b0} + (x_q[WIDTH-1] ? {2'b00, y} : '0);
    assign sub  = (sum >= mm) ? sum - mm : sum;
    assign pn   = WIDTH'((sub >= mm) ? sub - mm : sub);
    assign last = (cnt_q == CW'(WIDTH - 1));

    // Next-state logic: accept, run REDUCE then MUL/SQR per exponent bit, finish with a one-cycle DONE.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        e_d     = e_q;
        x_d     = x_q;
        p_d     = p_q;
        acc_d   = acc_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        err_d   = err_q;
        done_d  = 1'b0;
        fin     = 1'b0;
        fin_val = acc_q;
        if (state_q == IDLE) begin
            if (start) begin
                m_d     = modulus;
                e_d     = exponent;
                x_d     = base;
                p_d     = '0;
                cnt_d   = '0;
                k_d     = '0;
                acc_d   = (modulus == WIDTH'(1)) ? '0 : WIDTH'(1);
                err_d   = (modulus == '0);
                state_d = REDUCE;
                fin     = (modulus == '0);
                fin_val = '0;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end else begin
            x_d   = x_q << 1;
            p_d   = pn;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                p_d   = '0;
                cnt_d = '0;
                if (state_q == REDUCE) begin
                    b_d     = pn;
                    x_d     = acc_q;
                    state_d = MUL;
`ifdef MODEXP_EARLY_EXIT_EN
                    fin     = (e_q == '0);
`endif
                end else if (state_q == MUL) begin
                    acc_d   = e_q[0] ? pn : acc_q;
                    x_d     = b_q;
                    state_d = SQR;
`ifdef MODEXP_EARLY_EXIT_EN
                    fin     = (e_q[WIDTH-1:1] == '0);
                    fin_val = e_q[0] ? pn : acc_q;
`endif
                end else begin
                    b_d     = pn;
                    x_d     = acc_q;
                    e_d     = e_q >> 1;
                    k_d     = k_q + 1'b1;
                    state_d = MUL;
                    fin     = (k_q == CW'(WIDTH - 1));
                end
            end
        end
        if (fin) begin
            state_d = DONE;
            done_d  = 1'b1;
            res_d   = fin_val;
        end
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; asynchronous active-low clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            m_q     <= '0;
            e_q     <= '0;
            x_q     <= '0;
            p_q     <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            e_q     <= e_d;
            x_q     <= x_d;
            p_q     <= p_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign result = res_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
endmodule
